// File: rtl/pong_pkg.sv
// Shared geometry, derived collision limits and FSM encoding for the pong engine and drawer.
package pong_pkg;

  localparam int DefFrameWidth   = 1280;
  localparam int DefFrameHeight  = 960;
  localparam int DefCursorWidth  = 20;
  localparam int DefCursorOffset = 20;
  localparam int DefCursorHeight = 160;
  localparam int DefBallSide     = 30;
  localparam int DefCursorSpeed  = 8;
  localparam int DefBallSpeed    = 4;

  // Limits derived from the default geometry; they are expressed as ball/paddle centres.
  localparam int CursorPyMin   = DefCursorHeight / 2;
  localparam int CursorPyMax   = DefFrameHeight - DefCursorHeight / 2;
  localparam int BallPyMin     = DefBallSide / 2;
  localparam int BallPyMax     = DefFrameHeight - DefBallSide / 2;
  localparam int PaddleLeftPx  = DefCursorOffset + DefCursorWidth + DefBallSide / 2;
  localparam int PaddleRightPx = DefFrameWidth - PaddleLeftPx;
  localparam int MissLeftPx    = DefBallSide / 2;
  localparam int MissRightPx   = DefFrameWidth - DefBallSide / 2;
  localparam int HitReach      = DefCursorHeight / 2 + DefBallSide / 2;

  typedef enum logic [2:0] {
    StIdle,
    StCursor,
    StBall,
    StCollide,
    StCommit
  } pong_state_e;

  function automatic logic signed [12:0] abs13(input logic signed [12:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// Next paddle centre from the current centre and up/down buttons, clamped to the frame.
module pong_paddle #(
  parameter int CURSOR_SPEED = 8,
  parameter int PY_MIN       = 80,
  parameter int PY_MAX       = 880
) (
  input  logic [11:0] py_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  output logic [11:0] py_o
);

  localparam logic signed [12:0] Step  = 13'(CURSOR_SPEED);
  localparam logic signed [12:0] PyMin = 13'(PY_MIN);
  localparam logic signed [12:0] PyMax = 13'(PY_MAX);

  logic signed [12:0] step_py;

  always_comb begin
    step_py = $signed({1'b0, py_i});
    if (btn_up_i && !btn_down_i) begin
      step_py = step_py - Step;
    end else if (btn_down_i && !btn_up_i) begin
      step_py = step_py + Step;
    end
    if (step_py < PyMin) begin
      step_py = PyMin;
    end else if (step_py > PyMax) begin
      step_py = PyMax;
    end
    py_o = step_py[11:0];
  end

endmodule

// File: rtl/pong_engine.sv
// Per-frame pong game update: paddles, ball motion, collisions and scoring over a 4-cycle FSM.
module pong_engine
  import pong_pkg::*;
#(
  parameter int FRAME_WIDTH   = DefFrameWidth,
  parameter int FRAME_HEIGHT  = DefFrameHeight,
  parameter int CURSOR_WIDTH  = DefCursorWidth,
  parameter int CURSOR_OFFSET = DefCursorOffset,
  parameter int CURSOR_HEIGHT = DefCursorHeight,
  parameter int BALL_SIDE     = DefBallSide,
  parameter int CURSOR_SPEED  = DefCursorSpeed,
  parameter int BALL_SPEED    = DefBallSpeed
) (
  input  logic        pxClk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic        btn_left_up,
  input  logic        btn_left_down,
  input  logic        btn_right_up,
  input  logic        btn_right_down,
  output logic [11:0] cursor_left_py,
  output logic [11:0] cursor_right_py,
  output logic [11:0] ball_px,
  output logic [11:0] ball_py,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        busy
);

  localparam int BallHalf = BALL_SIDE / 2;
  localparam int PadFace  = CURSOR_OFFSET + CURSOR_WIDTH + BallHalf;

  localparam logic signed [12:0] WallTop  = 13'(BallHalf);
  localparam logic signed [12:0] WallBot  = 13'(FRAME_HEIGHT - BallHalf);
  localparam logic signed [12:0] PadLeft  = 13'(PadFace);
  localparam logic signed [12:0] PadRight = 13'(FRAME_WIDTH - PadFace);
  localparam logic signed [12:0] MissLeft = 13'(BallHalf);
  localparam logic signed [12:0] MissRight = 13'(FRAME_WIDTH - BallHalf);
  localparam logic signed [12:0] Reach    = 13'(CURSOR_HEIGHT / 2 + BallHalf);
  localparam logic signed [12:0] BallStep = 13'(BALL_SPEED);
  localparam logic signed [12:0] CenterX  = 13'(FRAME_WIDTH / 2);
  localparam logic signed [12:0] CenterY  = 13'(FRAME_HEIGHT / 2);

  pong_state_e state_q, state_d;

  logic [11:0] cur_l_q, cur_r_q, pad_l_q, pad_r_q, pad_l_next, pad_r_next;
  logic [11:0] ball_x_q, ball_y_q;
  logic        dx_pos_q, dy_pos_q;
  logic [3:0]  score_l_q, score_r_q;
  logic signed [12:0] bx_q, by_q;

  logic [11:0] col_px, col_py;
  logic        col_dx, col_dy;
  logic [3:0]  col_sl, col_sr;
  logic signed [12:0] dist_l, dist_r;

  pong_paddle #(
    .CURSOR_SPEED(CURSOR_SPEED),
    .PY_MIN      (CURSOR_HEIGHT / 2),
    .PY_MAX      (FRAME_HEIGHT - CURSOR_HEIGHT / 2)
  ) u_paddle_left (
    .py_i      (cur_l_q),
    .btn_up_i  (btn_left_up),
    .btn_down_i(btn_left_down),
    .py_o      (pad_l_next)
  );

  pong_paddle #(
    .CURSOR_SPEED(CURSOR_SPEED),
    .PY_MIN      (CURSOR_HEIGHT / 2),
    .PY_MAX      (FRAME_HEIGHT - CURSOR_HEIGHT / 2)
  ) u_paddle_right (
    .py_i      (cur_r_q),
    .btn_up_i  (btn_right_up),
    .btn_down_i(btn_right_down),
    .py_o      (pad_r_next)
  );

  always_ff @(posedge pxClk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (frame_tick && !pause) state_d = StCursor;
      StCursor:  state_d = StBall;
      StBall:    state_d = StCollide;
      StCollide: state_d = StCommit;
      StCommit:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  // Collision uses the ball position after this frame's move and this frame's paddles.
  always_comb begin
    col_px = bx_q[11:0];
    col_py = by_q[11:0];
    col_dx = dx_pos_q;
    col_dy = dy_pos_q;
    col_sl = score_l_q;
    col_sr = score_r_q;
    dist_l = by_q - $signed({1'b0, pad_l_q});
    dist_r = by_q - $signed({1'b0, pad_r_q});
    if (by_q <= WallTop) begin
      col_py = WallTop[11:0];
      col_dy = 1'b1;
    end else if (by_q >= WallBot) begin
      col_py = WallBot[11:0];
      col_dy = 1'b0;
    end
    if (!dx_pos_q && bx_q <= PadLeft && bx_q > MissLeft && abs13(dist_l) < Reach) begin
      col_px = PadLeft[11:0];
      col_dx = 1'b1;
    end
    if (dx_pos_q && bx_q >= PadRight && bx_q < MissRight && abs13(dist_r) < Reach) begin
      col_px = PadRight[11:0];
      col_dx = 1'b0;
    end
    // A miss re-serves from the centre toward the conceding side, ignoring wall fixes.
    if (bx_q <= MissLeft) begin
      col_sr = score_r_q + 4'd1;
      col_px = CenterX[11:0];
      col_py = CenterY[11:0];
      col_dx = 1'b0;
      col_dy = dy_pos_q;
    end else if (bx_q >= MissRight) begin
      col_sl = score_l_q + 4'd1;
      col_px = CenterX[11:0];
      col_py = CenterY[11:0];
      col_dx = 1'b1;
      col_dy = dy_pos_q;
    end
  end

  always_ff @(posedge pxClk or posedge rst) begin
    if (rst) begin
      cur_l_q   <= CenterY[11:0];
      cur_r_q   <= CenterY[11:0];
      pad_l_q   <= CenterY[11:0];
      pad_r_q   <= CenterY[11:0];
      ball_x_q  <= CenterX[11:0];
      ball_y_q  <= CenterY[11:0];
      bx_q      <= CenterX;
      by_q      <= CenterY;
      dx_pos_q  <= 1'b1;
      dy_pos_q  <= 1'b1;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
    end else begin
      unique case (state_q)
        StCursor: begin
          pad_l_q <= pad_l_next;
          pad_r_q <= pad_r_next;
        end
        StBall: begin
          bx_q <= $signed({1'b0, ball_x_q}) + (dx_pos_q ? BallStep : -BallStep);
          by_q <= $signed({1'b0, ball_y_q}) + (dy_pos_q ? BallStep : -BallStep);
        end
        // Visible state is written on entry to COMMIT, all fields together.
        StCollide: begin
          cur_l_q   <= pad_l_q;
          cur_r_q   <= pad_r_q;
          ball_x_q  <= col_px;
          ball_y_q  <= col_py;
          dx_pos_q  <= col_dx;
          dy_pos_q  <= col_dy;
          score_l_q <= col_sl;
          score_r_q <= col_sr;
        end
        default: ;
      endcase
    end
  end

  assign cursor_left_py  = cur_l_q;
  assign cursor_right_py = cur_r_q;
  assign ball_px         = ball_x_q;
  assign ball_py         = ball_y_q;
  assign score_left      = score_l_q;
  assign score_right     = score_r_q;

endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameter FRAME_WIDTH, 1280, visible pixels per line.
REQ-002 Parameter FRAME_HEIGHT, 960, visible lines per frame.
REQ-003 Parameter CURSOR_WIDTH, 20; CURSOR_OFFSET, 20; CURSOR_HEIGHT, 160; BALL_SIDE, 30: geometry shared with the drawer.
REQ-004 Parameter CURSOR_SPEED, 8, paddle pixels per frame; BALL_SPEED, 4, ball pixels per frame per axis.
REQ-005 pxClk in 1: the block's single clock, the pixel clock.
REQ-006 rst in 1: asynchronous, active-high reset.
REQ-007 frame_tick in 1: one-cycle pulse, once per frame at vblank start.
REQ-008 pause in 1: high freezes all game state.
REQ-009 btn_left_up, btn_left_down, btn_right_up, btn_right_down in 1 each: paddle controls, already synchronised.
REQ-010 cursor_left_py, cursor_right_py out 12: paddle centre line.
REQ-011 ball_px, ball_py out 12: ball centre pixel.
REQ-012 score_left, score_right out 4: points won.
REQ-013 busy out 1: high while an update is in progress.

Function
REQ-014 FSM states are IDLE, CURSOR, BALL, COLLIDE, COMMIT; each non-IDLE state lasts exactly one cycle.
REQ-015 IDLE->CURSOR on frame_tick=1 and pause=0; otherwise the FSM stays in IDLE; COMMIT->IDLE always.
REQ-016 frame_tick while busy=1 is ignored; it is neither queued nor counted.
REQ-017 All outputs are registered and change only on the COMMIT cycle, giving 4 cycles from frame_tick to new outputs; busy=1 in CURSOR..COMMIT.
REQ-018 CURSOR: up moves the paddle by -CURSOR_SPEED and down by +CURSOR_SPEED; both or neither pressed leaves it unchanged.
REQ-019 Paddle centre is clamped to [CURSOR_HEIGHT/2, FRAME_HEIGHT-CURSOR_HEIGHT/2] = [80, 880].
REQ-020 BALL: px += dx*BALL_SPEED and py += dy*BALL_SPEED, with dx, dy in {+1,-1}; arithmetic is signed 13-bit to avoid underflow.
REQ-021 COLLIDE, vertical: py <= 15 gives py=15, dy=+1; py >= 945 gives py=945, dy=-1.
REQ-022 COLLIDE, left paddle: dx=-1, px <= 55, px > 15 and |py - cursor_left_py| < 95 give px=55, dx=+1.
REQ-023 COLLIDE, right paddle: dx=+1, px >= 1225, px < 1265 and |py - cursor_right_py| < 95 give px=1225, dx=-1.
REQ-024 Miss: px <= 15 increments score_right; px >= 1265 increments score_left; the ball returns to (640, 480) with dy unchanged and dx pointing toward the conceding player.
REQ-025 Scores wrap from 15 to 0.
REQ-026 Wall and paddle corrections in the same COLLIDE cycle both apply; a miss overrides a wall correction.
REQ-027 Collision tests use the paddle positions computed in the same frame's CURSOR state.
REQ-028 pause rising while busy=1 lets the current update finish.

Reset
REQ-029 rst=1 forces, asynchronously: FSM=IDLE, busy=0, cursors=480, ball=(640, 480), dx=+1, dy=+1, scores=0.
REQ-030 rst asserted mid-update discards the update, so no partial COMMIT reaches the outputs.
REQ-031 Reset values hold until the first qualifying frame_tick after rst falls.

Structure
REQ-032 Geometry defaults, the derived limits (80, 880, 15, 945, 55, 1225, 1265) and the FSM state encoding belong in a shared package, pong_pkg, which the drawer also uses.
REQ-033 A single sub-module, pong_paddle, is instantiated twice to implement REQ-018/019.

Verification
REQ-034 Reset, then frame_tick with no buttons -> after 4 cycles ball=(644, 484), cursors=480, busy high for 4 cycles.
REQ-035 btn_left_up held for 60 frames -> cursor_left_py=80 from frame 50 on; all four buttons held -> no change.
REQ-036 Ball at (640, 943) moving down -> next COMMIT py=945, dy=-1; the following frame py=941.
REQ-037 cursor_left_py=480, ball (58, 500) moving left -> px=55, dx=+1; same test with cursor_left_py=880 -> score_right=1 and ball=(640, 480) once px<=15.
REQ-038 frame_tick pulses 2 cycles apart -> only one update; rst pulse on the BALL cycle -> outputs equal reset values.
REQ-039 score_right=15 and the left player misses -> score_right=0; pause=1 with ticks -> outputs frozen and busy=0.
